// File: rtl/subslot_pkg.sv
// subslot_pkg: shared state type and constants for the subslot expander probe.
// Build option: SUBSLOT_PROBE_DUAL_PATTERN_EN adds a second inverted-pattern check.
`timescale 1ns/1ps
package subslot_pkg;

   // Expander control register lives at the top byte of every primary slot.
   localparam logic [15:0] EXPANDER_ADDR        = 16'hFFFF;
   localparam logic [7:0]  DEFAULT_TEST_PATTERN = 8'h5A;
   localparam int unsigned DEFAULT_ACK_TIMEOUT  = 64;

   typedef enum logic [3:0] {
      StIdle,
      StRdOrig,
      StWrTest,
      StRdTest,
`ifdef SUBSLOT_PROBE_DUAL_PATTERN_EN
      StWrTest2,
      StRdTest2,
`endif
      StWrRestore,
      StGap,
      StNext,
      StDone
   } probe_state_e;

   // True for transaction states that drive a bus write.
   function automatic logic is_write_state(probe_state_e st);
      logic wr;
      wr = 1'b0;
      case (st)
         StWrTest:    wr = 1'b1;
`ifdef SUBSLOT_PROBE_DUAL_PATTERN_EN
         StWrTest2:   wr = 1'b1;
`endif
         StWrRestore: wr = 1'b1;
         default:     wr = 1'b0;
      endcase
      return wr;
   endfunction

endpackage

// File: rtl/subslot_probe_xfer.sv
// subslot_probe_xfer: completion/timeout engine for one probe bus transaction.
// The sequencer owns bus_req; this block qualifies acks and times out silent slots.
`timescale 1ns/1ps
module subslot_probe_xfer
   import subslot_pkg::*;
#(
   parameter int unsigned ACK_TIMEOUT = DEFAULT_ACK_TIMEOUT
) (
   input  logic clk,
   input  logic reset_n,
   input  logic req,
   input  logic ack,
   output logic xfer_done,
   output logic xfer_timeout
);

   localparam int unsigned CntW = $clog2(ACK_TIMEOUT + 1);

   logic [CntW-1:0] cnt_q;

   // Wait counter: req is always low for at least one cycle between transactions,
   // so clearing while low restarts the count on every req rising edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else if (!req) begin
         cnt_q <= '0;
      end else if (!ack) begin
         cnt_q <= cnt_q + CntW'(1);
      end
   end

   // Acks while no request is outstanding are ignored.
   assign xfer_done    = req & ack;
   // Fires in the last allowed cycle so req is high for exactly ACK_TIMEOUT cycles.
   assign xfer_timeout = req & ~ack & (cnt_q == CntW'(ACK_TIMEOUT - 1));

endmodule

// File: rtl/subslot_probe.sv
// subslot_probe: boot-time initiator that probes primary slots 0..3 for a subslot
// expander at 16'hFFFF (write pattern, expect inverted echo, restore original byte).
// Build option: define SUBSLOT_PROBE_DUAL_PATTERN_EN to also write ~pattern and
// expect the plain pattern back, rejecting stuck or partially decoded latches.
`timescale 1ns/1ps
module subslot_probe
   import subslot_pkg::*;
#(
   parameter logic [7:0]  TEST_PATTERN = DEFAULT_TEST_PATTERN,
   parameter int unsigned ACK_TIMEOUT  = DEFAULT_ACK_TIMEOUT
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic [1:0]  probe_slot,
   output logic        bus_req,
   output logic        bus_wr,
   output logic [15:0] bus_addr,
   output logic [7:0]  bus_wdata,
   input  logic        bus_ack,
   input  logic [7:0]  bus_rdata,
   output logic [3:0]  expander_found,
   output logic [3:0]  timeout_err
);

   probe_state_e state_q;
   probe_state_e after_gap_q;  // transaction to launch when GAP ends
   logic [7:0]   orig_q;
   logic         hit_q;
   logic         xfer_done;
   logic         xfer_timeout;
   logic [7:0]   wdata_next;

   subslot_probe_xfer #(
      .ACK_TIMEOUT (ACK_TIMEOUT)
   ) u_xfer (
      .clk          (clk),
      .reset_n      (reset_n),
      .req          (bus_req),
      .ack          (bus_ack),
      .xfer_done    (xfer_done),
      .xfer_timeout (xfer_timeout)
   );

   assign bus_addr = bus_req ? EXPANDER_ADDR : 16'h0000;

   // Write data for the transaction launched out of GAP. An expander inverts reads,
   // so its original byte is ~orig; plain RAM gets its raw byte back.
   always_comb begin
      wdata_next = 8'h00;
      case (after_gap_q)
         StWrTest:    wdata_next = TEST_PATTERN;
`ifdef SUBSLOT_PROBE_DUAL_PATTERN_EN
         StWrTest2:   wdata_next = ~TEST_PATTERN;
`endif
         StWrRestore: wdata_next = hit_q ? ~orig_q : orig_q;
         default:     wdata_next = 8'h00;
      endcase
   end

   // Probe sequencer: walks each slot through read/test/restore; all outputs registered.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= StIdle;
         after_gap_q    <= StIdle;
         orig_q         <= 8'h00;
         hit_q          <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
         probe_slot     <= 2'd0;
         bus_req        <= 1'b0;
         bus_wr         <= 1'b0;
         bus_wdata      <= 8'h00;
         expander_found <= 4'h0;
         timeout_err    <= 4'h0;
      end else begin
         done <= 1'b0;
         case (state_q)
            StIdle: begin
               if (start) begin
                  expander_found <= 4'h0;
                  timeout_err    <= 4'h0;
                  probe_slot     <= 2'd0;
                  busy           <= 1'b1;
                  bus_req        <= 1'b1;
                  bus_wr         <= 1'b0;
                  bus_wdata      <= 8'h00;
                  state_q        <= StRdOrig;
               end
            end
            StGap: begin
               bus_req   <= 1'b1;
               bus_wr    <= is_write_state(after_gap_q);
               bus_wdata <= wdata_next;
               state_q   <= after_gap_q;
            end
            StNext: begin
               if (probe_slot == 2'd3) begin
                  done    <= 1'b1;
                  busy    <= 1'b0;
                  state_q <= StDone;
               end else begin
                  probe_slot <= probe_slot + 2'd1;
                  bus_req    <= 1'b1;
                  bus_wr     <= 1'b0;
                  bus_wdata  <= 8'h00;
                  state_q    <= StRdOrig;
               end
            end
            StDone: begin
               state_q <= StIdle;
            end
            default: begin
               // Transaction states: bus_req is high for the whole state.
               if (xfer_done) begin
                  bus_req <= 1'b0;
                  case (state_q)
                     StRdOrig: begin
                        orig_q      <= bus_rdata;
                        after_gap_q <= StWrTest;
                        state_q     <= StGap;
                     end
                     StWrTest: begin
                        after_gap_q <= StRdTest;
                        state_q     <= StGap;
                     end
                     StRdTest: begin
                        hit_q       <= (bus_rdata == ~TEST_PATTERN);
`ifdef SUBSLOT_PROBE_DUAL_PATTERN_EN
                        after_gap_q <= StWrTest2;
`else
                        after_gap_q <= StWrRestore;
`endif
                        state_q     <= StGap;
                     end
`ifdef SUBSLOT_PROBE_DUAL_PATTERN_EN
                     StWrTest2: begin
                        after_gap_q <= StRdTest2;
                        state_q     <= StGap;
                     end
                     StRdTest2: begin
                        hit_q       <= hit_q & (bus_rdata == TEST_PATTERN);
                        after_gap_q <= StWrRestore;
                        state_q     <= StGap;
                     end
`endif
                     StWrRestore: begin
                        expander_found[probe_slot] <= hit_q;
                        state_q                    <= StNext;
                     end
                     default: begin
                        state_q <= StIdle;
                     end
                  endcase
               end else if (xfer_timeout) begin
                  // Silent slot: abandon the remaining transactions for it.
                  bus_req                    <= 1'b0;
                  timeout_err[probe_slot]    <= 1'b1;
                  expander_found[probe_slot] <= 1'b0;
                  state_q                    <= StNext;
               end
            end
         endcase
      end
   end

endmodule
